// File: rtl/z80_bus_arbiter_if.sv
// Signal bundle between the z80 core, the video/DMA requesters, the memory
// block and the bus arbiter. The arbiter connects through the master modport.
interface z80_bus_arbiter_if;
    logic [15:0] CPU_A;
    logic [7:0]  CPU_DO;
    logic        CPU_W;
    logic        HOLD;
    logic        VID_REQ;
    logic [15:0] VID_ADDR;
    logic        VID_ACK;
    logic [7:0]  VID_DATA;
    logic        DMA_REQ;
    logic        DMA_WE;
    logic [15:0] DMA_ADDR;
    logic [7:0]  DMA_DO;
    logic        DMA_ACK;
    logic [7:0]  DMA_DATA;
    logic [15:0] MEM_A;
    logic [7:0]  MEM_DO;
    logic        MEM_W;
    logic [7:0]  MEM_DI;

    modport master (
        input  CPU_A, CPU_DO, CPU_W,
        input  VID_REQ, VID_ADDR,
        input  DMA_REQ, DMA_WE, DMA_ADDR, DMA_DO,
        input  MEM_DI,
        output HOLD, VID_ACK, VID_DATA, DMA_ACK, DMA_DATA,
        output MEM_A, MEM_DO, MEM_W
    );

    modport slave (
        output CPU_A, CPU_DO, CPU_W,
        output VID_REQ, VID_ADDR,
        output DMA_REQ, DMA_WE, DMA_ADDR, DMA_DO,
        output MEM_DI,
        input  HOLD, VID_ACK, VID_DATA, DMA_ACK, DMA_DATA,
        input  MEM_A, MEM_DO, MEM_W
    );
endinterface

// File: rtl/z80_bus_arbiter.sv
// Shares one synchronous memory port (1-cycle read latency) between the z80,
// a video fetch port and a DMA port. The CPU is frozen via HOLD, its pending
// address is saved and replayed on resume so MEM_DI is valid when it restarts.
module z80_bus_arbiter #(
    parameter int unsigned CPU_MIN = 4,
    parameter int unsigned CNT_W   = 4
) (
    input  logic               CLOCK,
    input  logic               RESET,
    z80_bus_arbiter_if.master  bus
);
    localparam logic [2:0] S_CPU     = 3'd0;
    localparam logic [2:0] S_RELEASE = 3'd1;
    localparam logic [2:0] S_VA      = 3'd2;
    localparam logic [2:0] S_VD      = 3'd3;
    localparam logic [2:0] S_DA      = 3'd4;
    localparam logic [2:0] S_DD      = 3'd5;
    localparam logic [2:0] S_RESUME  = 3'd6;

    localparam logic [CNT_W-1:0] GUARD_INIT = CNT_W'(CPU_MIN);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] guard;
    logic [15:0]      save_a;
    logic             hold_q;
    logic             dma_done;
    logic             dma_ack_c;

    // Next-state selection; dma_done limits each preemption to one DMA access
    always_comb begin
        state_nxt = state;
        case (state)
            S_CPU: begin
                if (!bus.CPU_W && (bus.VID_REQ || (bus.DMA_REQ && guard == '0)))
                    state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (bus.VID_REQ)      state_nxt = S_VA;
                else if (bus.DMA_REQ) state_nxt = S_DA;
                else                  state_nxt = S_RESUME;
            end
            S_VA: state_nxt = S_VD;
            S_VD: begin
                if (bus.VID_REQ)                    state_nxt = S_VA;
                else if (bus.DMA_REQ && !dma_done)  state_nxt = S_DA;
                else                                state_nxt = S_RESUME;
            end
            S_DA: begin
                if (!bus.DMA_WE)      state_nxt = S_DD;
                else if (bus.VID_REQ) state_nxt = S_VA;
                else                  state_nxt = S_RESUME;
            end
            S_DD: begin
                if (bus.VID_REQ) state_nxt = S_VA;
                else             state_nxt = S_RESUME;
            end
            S_RESUME: state_nxt = S_CPU;
            default:  state_nxt = S_CPU;
        endcase
    end

    // State, guard counter, saved CPU address and registered HOLD
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state    <= S_CPU;
            guard    <= '0;
            save_a   <= '0;
            hold_q   <= 1'b1;
            dma_done <= 1'b0;
        end else begin
            state  <= state_nxt;
            hold_q <= (state_nxt == S_CPU);
            if (state == S_CPU && guard != '0)
                guard <= guard - 1'b1;
            else if (state == S_RESUME)
                guard <= GUARD_INIT;
            if (state == S_RELEASE) begin
                save_a   <= bus.CPU_A;
                dma_done <= 1'b0;
            end else if (dma_ack_c) begin
                dma_done <= 1'b1;
            end
        end
    end

    // Memory port mux and acknowledge decode for the current state
    always_comb begin
        bus.MEM_A   = bus.CPU_A;
        bus.MEM_DO  = bus.CPU_DO;
        bus.MEM_W   = 1'b0;
        bus.VID_ACK = 1'b0;
        dma_ack_c   = 1'b0;
        case (state)
            S_CPU:    bus.MEM_W = bus.CPU_W;
            S_VA:     bus.MEM_A = bus.VID_ADDR;
            S_VD:     bus.VID_ACK = 1'b1;
            S_DA: begin
                bus.MEM_A = bus.DMA_ADDR;
                if (bus.DMA_WE) begin
                    bus.MEM_W  = 1'b1;
                    bus.MEM_DO = bus.DMA_DO;
                    dma_ack_c  = 1'b1;
                end
            end
            S_DD:     dma_ack_c = 1'b1;
            S_RESUME: bus.MEM_A = save_a;
            default:  ;
        endcase
    end

    assign bus.DMA_ACK  = dma_ack_c;
    assign bus.HOLD     = hold_q;
    assign bus.VID_DATA = bus.MEM_DI;
    assign bus.DMA_DATA = bus.MEM_DI;
endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed self-checking bench for z80_bus_arbiter with a 1-cycle-latency
// synchronous memory model.
module tb_z80_bus_arbiter;
    logic CLOCK;
    logic RESET;
    int   checks;
    int   failures;

    logic        pre_we;
    logic [15:0] pre_addr;
    logic [7:0]  pre_data;
    logic [7:0]  mem [0:65535];

    z80_bus_arbiter_if bus ();

    z80_bus_arbiter #(.CPU_MIN(4), .CNT_W(4)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Synchronous memory: write on MEM_W, read data one cycle later
    always @(posedge CLOCK) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (bus.MEM_W)
            mem[bus.MEM_A] <= bus.MEM_DO;
        bus.MEM_DI <= mem[bus.MEM_A];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we   = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int low;
        int vack;
        int dack;
        int both;
        logic [7:0] exp_v [3];
        exp_v[0] = 8'hA5;
        exp_v[1] = 8'hB6;
        exp_v[2] = 8'hC7;
        checks   = 0;
        failures = 0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        RESET    = 1'b1;
        bus.CPU_A    = 16'h0100;
        bus.CPU_DO   = '0;
        bus.CPU_W    = 1'b0;
        bus.VID_REQ  = 1'b0;
        bus.VID_ADDR = '0;
        bus.DMA_REQ  = 1'b0;
        bus.DMA_WE   = 1'b0;
        bus.DMA_ADDR = '0;
        bus.DMA_DO   = '0;

        poke(16'h0100, 8'h11);
        poke(16'h4000, 8'hA5);
        poke(16'h4001, 8'hB6);
        poke(16'h4002, 8'hC7);
        poke(16'h8000, 8'h00);
        poke(16'h1234, 8'h5A);

        check("rst_hold", 32'(bus.HOLD), 32'd1);
        check("rst_vack", 32'(bus.VID_ACK), 32'd0);
        check("rst_dack", 32'(bus.DMA_ACK), 32'd0);
        check("rst_mema", 32'(bus.MEM_A), 32'h0100);
        check("rst_memw", 32'(bus.MEM_W), 32'd0);
        RESET = 1'b0;
        tick();
        check("post_rst_hold", 32'(bus.HOLD), 32'd1);

        // Video preempt of an idle CPU reading 0x0100
        bus.VID_REQ  = 1'b1;
        bus.VID_ADDR = 16'h4000;
        tick();
        check("vp_rel_hold", 32'(bus.HOLD), 32'd0);
        check("vp_rel_mema", 32'(bus.MEM_A), 32'h0100);
        check("vp_rel_memw", 32'(bus.MEM_W), 32'd0);
        tick();
        check("vp_va_mema", 32'(bus.MEM_A), 32'h4000);
        check("vp_va_hold", 32'(bus.HOLD), 32'd0);
        bus.VID_REQ = 1'b0;
        tick();
        check("vp_vd_ack", 32'(bus.VID_ACK), 32'd1);
        check("vp_vd_data", 32'(bus.VID_DATA), 32'hA5);
        check("vp_vd_hold", 32'(bus.HOLD), 32'd0);
        tick();
        check("vp_res_mema", 32'(bus.MEM_A), 32'h0100);
        check("vp_res_ack", 32'(bus.VID_ACK), 32'd0);
        check("vp_res_hold", 32'(bus.HOLD), 32'd0);
        tick();
        check("vp_cpu_hold", 32'(bus.HOLD), 32'd1);
        check("vp_cpu_di", 32'(bus.MEM_DI), 32'h11);

        repeat (6) tick();

        // CPU write to 0x8000 defers the DMA preemption by one cycle
        bus.CPU_A    = 16'h8000;
        bus.CPU_DO   = 8'h77;
        bus.CPU_W    = 1'b1;
        bus.DMA_REQ  = 1'b1;
        bus.DMA_WE   = 1'b0;
        bus.DMA_ADDR = 16'h8000;
        #1;
        check("wd_memw", 32'(bus.MEM_W), 32'd1);
        check("wd_mema", 32'(bus.MEM_A), 32'h8000);
        tick();
        check("wd_hold_after", 32'(bus.HOLD), 32'd1);
        bus.CPU_W = 1'b0;
        tick();
        check("wd_rel_hold", 32'(bus.HOLD), 32'd0);
        check("wd_rel_memw", 32'(bus.MEM_W), 32'd0);
        tick();
        check("wd_da_mema", 32'(bus.MEM_A), 32'h8000);
        check("wd_da_ack", 32'(bus.DMA_ACK), 32'd0);
        bus.DMA_REQ = 1'b0;
        tick();
        check("wd_dd_ack", 32'(bus.DMA_ACK), 32'd1);
        check("wd_dd_data", 32'(bus.DMA_DATA), 32'h77);
        tick();
        check("wd_res_mema", 32'(bus.MEM_A), 32'h8000);
        check("wd_res_ack", 32'(bus.DMA_ACK), 32'd0);
        tick();
        check("wd_cpu_hold", 32'(bus.HOLD), 32'd1);
        check("wd_cpu_di", 32'(bus.MEM_DI), 32'h77);
        bus.CPU_A = 16'h0100;

        repeat (6) tick();

        // DMA write of 0x3C to 0x2000
        bus.DMA_REQ  = 1'b1;
        bus.DMA_WE   = 1'b1;
        bus.DMA_ADDR = 16'h2000;
        bus.DMA_DO   = 8'h3C;
        tick();
        tick();
        check("dw_memw", 32'(bus.MEM_W), 32'd1);
        check("dw_ack", 32'(bus.DMA_ACK), 32'd1);
        check("dw_mema", 32'(bus.MEM_A), 32'h2000);
        check("dw_memdo", 32'(bus.MEM_DO), 32'h3C);
        check("dw_vack", 32'(bus.VID_ACK), 32'd0);
        bus.DMA_REQ = 1'b0;
        tick();
        check("dw_res_ack", 32'(bus.DMA_ACK), 32'd0);
        check("dw_res_hold", 32'(bus.HOLD), 32'd0);
        bus.DMA_WE = 1'b0;
        tick();
        check("dw_cpu_hold", 32'(bus.HOLD), 32'd1);

        // Video read-back of 0x2000, raised while the guard is still running
        bus.VID_REQ  = 1'b1;
        bus.VID_ADDR = 16'h2000;
        tick();
        check("vg_rel_hold", 32'(bus.HOLD), 32'd0);
        tick();
        bus.VID_REQ = 1'b0;
        tick();
        check("vg_vd_ack", 32'(bus.VID_ACK), 32'd1);
        check("vg_vd_data", 32'(bus.VID_DATA), 32'h3C);
        tick();
        tick();
        check("vg_cpu_hold", 32'(bus.HOLD), 32'd1);

        // DMA held high: each resume leaves the CPU at least 4 running cycles
        bus.DMA_REQ  = 1'b1;
        bus.DMA_WE   = 1'b0;
        bus.DMA_ADDR = 16'h1234;
        for (int r = 0; r < 2; r++) begin
            n = 0;
            while (bus.HOLD === 1'b1 && n < 20) begin
                n++;
                tick();
            end
            check("guard_run", 32'((n >= 4) && (n < 20)), 32'd1);
            check("guard_rel_hold", 32'(bus.HOLD), 32'd0);
            repeat (4) tick();
            check("guard_back_hold", 32'(bus.HOLD), 32'd1);
        end
        bus.DMA_REQ = 1'b0;

        repeat (6) tick();

        // Simultaneous video (3 back-to-back) and DMA read of 0x1234
        bus.VID_REQ  = 1'b1;
        bus.VID_ADDR = 16'h4000;
        bus.DMA_REQ  = 1'b1;
        bus.DMA_WE   = 1'b0;
        bus.DMA_ADDR = 16'h1234;
        tick();
        low  = 0;
        vack = 0;
        dack = 0;
        both = 0;
        n    = 0;
        while (bus.HOLD === 1'b0 && n < 30) begin
            low++;
            n++;
            if (bus.VID_ACK === 1'b1 && bus.DMA_ACK === 1'b1)
                both++;
            if (bus.VID_ACK === 1'b1) begin
                if (vack < 3)
                    check("ct_vdata", 32'(bus.VID_DATA), 32'(exp_v[vack]));
                vack++;
                bus.VID_ADDR = 16'h4000 + 16'(vack);
                if (vack == 3)
                    bus.VID_REQ = 1'b0;
            end
            if (bus.DMA_ACK === 1'b1) begin
                check("ct_ddata", 32'(bus.DMA_DATA), 32'h5A);
                dack++;
                bus.DMA_REQ = 1'b0;
            end
            tick();
        end
        check("ct_low", 32'(low), 32'd10);
        check("ct_vack", 32'(vack), 32'd3);
        check("ct_dack", 32'(dack), 32'd1);
        check("ct_both", 32'(both), 32'd0);
        check("ct_hold", 32'(bus.HOLD), 32'd1);
        bus.VID_REQ = 1'b0;
        bus.DMA_REQ = 1'b0;

        // Reset asserted in the middle of a video data phase
        bus.CPU_A    = 16'h0300;
        bus.VID_REQ  = 1'b1;
        bus.VID_ADDR = 16'h4000;
        tick();
        tick();
        bus.VID_REQ = 1'b0;
        tick();
        check("rv_vd_ack", 32'(bus.VID_ACK), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        check("rv_rst_ack", 32'(bus.VID_ACK), 32'd0);
        check("rv_rst_hold", 32'(bus.HOLD), 32'd1);
        check("rv_rst_mema", 32'(bus.MEM_A), 32'h0300);
        @(negedge CLOCK);
        RESET = 1'b0;
        tick();
        check("rv_post_hold", 32'(bus.HOLD), 32'd1);
        check("rv_post_mema", 32'(bus.MEM_A), 32'h0300);
        check("rv_post_ack", 32'(bus.VID_ACK), 32'd0);
        tick();
        check("rv_post2_hold", 32'(bus.HOLD), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
